render_scheduler: RTL and testbench

- Per-frame render sequencer that replaces the single-rasterizer manager.
- Optionally clears the screen with an internal fill scanner, then dispatches incoming triangles round-robin across NUM_LANES external rasterizer lanes.
- Merges lane pixel streams into one depth-tested output stream through a round-robin arbiter.
- Tracks frame completion (drain of all lanes) and reports it with a done pulse and a frame counter.
- Sits between the triangle producer and the framebuffer/depth-test stage.

---
 rtl/render_scheduler.sv | 226 ++++++++++++++++++++++
 tb/tb_render_scheduler.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/render_scheduler.sv
// Per-frame render sequencer: optional screen clear, round-robin triangle dispatch to rasterizer
// lanes, round-robin merge of lane pixel streams, and frame completion tracking.
package render_pkg;
   typedef logic [11:0] color12_t;
   typedef logic [31:0] q16_16_t;
   typedef struct packed {
      logic [15:0] x0;
      logic [15:0] y0;
      logic [15:0] x1;
      logic [15:0] y1;
      logic [15:0] x2;
      logic [15:0] y2;
      q16_16_t     z0;
      q16_16_t     z1;
      q16_16_t     z2;
      color12_t    color;
   } triangle_t;
endpackage

module render_scheduler
   import render_pkg::*;
#(
   parameter int unsigned WIDTH     = 320,
   parameter int unsigned HEIGHT    = 240,
   parameter int unsigned NUM_LANES = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      begin_frame,
   input  logic                      end_frame,
   input  logic                      fill_enable,
   input  color12_t                  fill_color,
   input  logic                      fill_valid,
   output logic                      fill_ready,
   input  triangle_t                 triangle,
   input  logic                      triangle_valid,
   output logic                      triangle_ready,
   output triangle_t                 lane_triangle,
   output logic [NUM_LANES-1:0]      lane_tri_valid,
   input  logic [NUM_LANES-1:0]      lane_tri_ready,
   input  logic [NUM_LANES-1:0]      lane_busy,
   input  logic [16*NUM_LANES-1:0]   lane_pixel_x,
   input  logic [16*NUM_LANES-1:0]   lane_pixel_y,
   input  logic [32*NUM_LANES-1:0]   lane_depth,
   input  logic [12*NUM_LANES-1:0]   lane_color,
   input  logic [NUM_LANES-1:0]      lane_valid,
   output logic [NUM_LANES-1:0]      lane_ready,
   output logic [15:0]               out_pixel_x,
   output logic [15:0]               out_pixel_y,
   output logic [31:0]               out_depth,
   output logic [11:0]               out_color,
   output logic                      out_compare_depth,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      busy,
   output logic                      frame_done,
   output logic [15:0]               frame_count
);

   localparam int unsigned PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_LANES - 1);
   localparam logic [15:0] X_LAST = 16'(WIDTH - 1);
   localparam logic [15:0] Y_LAST = 16'(HEIGHT - 1);

   typedef enum logic [2:0] {StIdle, StFill, StDraw, StDrain, StDone} state_t;

   state_t           state_q;
   logic [15:0]      x_q, y_q;
   logic [PTR_W-1:0] dispatch_q, prio_q, grant_q;
   logic             lock_q;
   color12_t         fill_color_q, frame_fill_q;
   logic [15:0]      frame_count_q;

   logic             arb_found;
   logic [PTR_W-1:0] arb_idx, grant;
   logic             merge_active, merge_valid;
   logic [15:0]      sel_x, sel_y;
   logic [31:0]      sel_depth;
   logic [11:0]      sel_color;

   // Round-robin search starting at prio_q; first valid lane wins.
   always_comb begin
      int unsigned cand;
      arb_found = 1'b0;
      arb_idx   = '0;
      cand      = 0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
         cand = 32'(prio_q) + i;
         if (cand >= NUM_LANES) cand = cand - NUM_LANES;
         if (!arb_found && lane_valid[cand]) begin
            arb_found = 1'b1;
            arb_idx   = PTR_W'(cand);
         end
      end
   end

   assign merge_active = (state_q == StDraw) || (state_q == StDrain);
   assign grant        = lock_q ? grant_q : arb_idx;
   assign merge_valid  = merge_active && (lock_q ? lane_valid[grant_q] : arb_found);

   always_comb begin
      sel_x     = '0;
      sel_y     = '0;
      sel_depth = '0;
      sel_color = '0;
      for (int unsigned l = 0; l < NUM_LANES; l++) begin
         if (PTR_W'(l) == grant) begin
            sel_x     = lane_pixel_x[16*l +: 16];
            sel_y     = lane_pixel_y[16*l +: 16];
            sel_depth = lane_depth[32*l +: 32];
            sel_color = lane_color[12*l +: 12];
         end
      end
   end

   always_comb begin
      fill_ready        = 1'b1;
      triangle_ready    = 1'b0;
      lane_triangle     = '0;
      lane_tri_valid    = '0;
      lane_ready        = '0;
      out_pixel_x       = '0;
      out_pixel_y       = '0;
      out_depth         = '0;
      out_color         = '0;
      out_compare_depth = 1'b0;
      out_valid         = 1'b0;
      unique case (state_q)
         StFill: begin
            out_valid   = 1'b1;
            out_pixel_x = x_q;
            out_pixel_y = y_q;
            out_depth   = 32'h7FFF_FFFF;
            out_color   = frame_fill_q;
         end
         StDraw, StDrain: begin
            if (state_q == StDraw) begin
               lane_triangle              = triangle;
               lane_tri_valid[dispatch_q] = triangle_valid;
               triangle_ready             = lane_tri_ready[dispatch_q];
            end
            out_valid         = merge_valid;
            out_pixel_x       = sel_x;
            out_pixel_y       = sel_y;
            out_depth         = sel_depth;
            out_color         = sel_color;
            out_compare_depth = 1'b1;
            if (merge_valid) lane_ready[grant] = out_ready;
         end
         default: ;
      endcase
   end

   assign busy        = (state_q != StIdle);
   assign frame_done  = (state_q == StDone);
   assign frame_count = frame_count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         x_q           <= '0;
         y_q           <= '0;
         dispatch_q    <= '0;
         prio_q        <= '0;
         grant_q       <= '0;
         lock_q        <= 1'b0;
         fill_color_q  <= '0;
         frame_fill_q  <= '0;
         frame_count_q <= '0;
      end else begin
         if (fill_valid) fill_color_q <= fill_color;
         case (state_q)
            StIdle: begin
               if (begin_frame) begin
                  if (fill_enable) begin
                     state_q      <= StFill;
                     frame_fill_q <= fill_color_q;
                     x_q          <= '0;
                     y_q          <= '0;
                  end else begin
                     state_q <= StDraw;
                  end
               end
            end
            StFill: begin
               if (out_ready) begin
                  if (x_q == X_LAST) begin
                     x_q <= '0;
                     if (y_q == Y_LAST) begin
                        y_q     <= '0;
                        state_q <= StDraw;
                     end else begin
                        y_q <= y_q + 16'd1;
                     end
                  end else begin
                     x_q <= x_q + 16'd1;
                  end
               end
            end
            StDraw: begin
               if (triangle_valid && triangle_ready) begin
                  dispatch_q <= (dispatch_q == PTR_LAST) ? '0 : dispatch_q + 1'b1;
               end
               if (end_frame) state_q <= StDrain;
            end
            StDrain: begin
               if (lane_busy == '0 && lane_valid == '0) state_q <= StDone;
            end
            StDone: begin
               frame_count_q <= frame_count_q + 16'd1;
               state_q       <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
         // Hold the grant across a stall so the presented pixel cannot change under backpressure.
         if (merge_valid && !out_ready) begin
            lock_q  <= 1'b1;
            grant_q <= grant;
         end else begin
            lock_q <= 1'b0;
            if (merge_valid) prio_q <= (grant == PTR_LAST) ? '0 : grant + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_render_scheduler.sv
// Directed bench for render_scheduler with a 4x2 screen and two lanes.
module tb_render_scheduler;
   import render_pkg::*;

   logic        clk, rst;
   logic        begin_frame, end_frame, fill_enable, fill_valid, fill_ready;
   color12_t    fill_color;
   triangle_t   triangle, lane_triangle;
   logic        triangle_valid, triangle_ready;
   logic [1:0]  lane_tri_valid, lane_tri_ready, lane_busy, lane_valid, lane_ready;
   logic [31:0] lane_pixel_x, lane_pixel_y;
   logic [63:0] lane_depth;
   logic [23:0] lane_color;
   logic [15:0] out_pixel_x, out_pixel_y, frame_count;
   logic [31:0] out_depth;
   logic [11:0] out_color;
   logic        out_compare_depth, out_valid, out_ready, busy, frame_done;

   int vecs = 0;
   int errs = 0;
   int exp_frames = 0;

   render_scheduler #(.WIDTH(4), .HEIGHT(2), .NUM_LANES(2)) dut (
      .clk(clk), .rst(rst), .begin_frame(begin_frame), .end_frame(end_frame),
      .fill_enable(fill_enable), .fill_color(fill_color), .fill_valid(fill_valid),
      .fill_ready(fill_ready), .triangle(triangle), .triangle_valid(triangle_valid),
      .triangle_ready(triangle_ready), .lane_triangle(lane_triangle),
      .lane_tri_valid(lane_tri_valid), .lane_tri_ready(lane_tri_ready), .lane_busy(lane_busy),
      .lane_pixel_x(lane_pixel_x), .lane_pixel_y(lane_pixel_y), .lane_depth(lane_depth),
      .lane_color(lane_color), .lane_valid(lane_valid), .lane_ready(lane_ready),
      .out_pixel_x(out_pixel_x), .out_pixel_y(out_pixel_y), .out_depth(out_depth),
      .out_color(out_color), .out_compare_depth(out_compare_depth), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy), .frame_done(frame_done), .frame_count(frame_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cyc();
      cyc();
      vecs++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || triangle_ready !== 1'b0 || frame_done !== 1'b0) begin
         errs++;
         $display("FAIL reset_ctrl: valid=%b busy=%b tri_rdy=%b done=%b, required all 0",
                  out_valid, busy, triangle_ready, frame_done);
      end
      vecs++;
      if (fill_ready !== 1'b1 || frame_count !== 16'd0 || lane_ready !== 2'b00) begin
         errs++;
         $display("FAIL reset_misc: fill_ready=%b count=%0d lane_ready=%b, required 1/0/00",
                  fill_ready, frame_count, lane_ready);
      end
      rst = 1'b0;
      cyc();
   endtask

   // Finish the current DRAW frame with idle lanes: DRAW -> DRAIN -> DONE -> IDLE.
   task automatic finish_frame();
      end_frame = 1'b1;
      cyc();
      end_frame = 1'b0;
      cyc();
      vecs++;
      if (frame_done !== 1'b1) begin
         errs++;
         $display("FAIL done_pulse: frame_done=%b, required 1", frame_done);
      end
      cyc();
      exp_frames++;
      vecs++;
      if (busy !== 1'b0 || frame_count !== 16'(exp_frames)) begin
         errs++;
         $display("FAIL frame_end: busy=%b count=%0d, required 0/%0d", busy, frame_count, exp_frames);
      end
   endtask

   task automatic test_fill();
      fill_color = 12'hABC;
      fill_valid = 1'b1;
      cyc();
      fill_valid  = 1'b0;
      fill_enable = 1'b1;
      out_ready   = 1'b1;
      begin_frame = 1'b1;
      cyc();
      begin_frame = 1'b0;
      for (int k = 0; k < 8; k++) begin
         vecs++;
         if (out_valid !== 1'b1 || out_pixel_x !== 16'(k % 4) || out_pixel_y !== 16'(k / 4) ||
             out_depth !== 32'h7FFF_FFFF || out_color !== 12'hABC || out_compare_depth !== 1'b0) begin
            errs++;
            $display("FAIL fill_px%0d: v=%b (%0d,%0d) d=%h c=%h cmp=%b, required 1 (%0d,%0d) 7fffffff abc 0",
                     k, out_valid, out_pixel_x, out_pixel_y, out_depth, out_color, out_compare_depth,
                     k % 4, k / 4);
         end
         cyc();
      end
      lane_tri_ready = 2'b01;
      #1;
      vecs++;
      if (busy !== 1'b1 || out_valid !== 1'b0 || triangle_ready !== 1'b1) begin
         errs++;
         $display("FAIL draw_entry: busy=%b valid=%b tri_rdy=%b, required 1/0/1",
                  busy, out_valid, triangle_ready);
      end
      lane_tri_ready = 2'b10;
      #1;
      vecs++;
      if (triangle_ready !== 1'b0) begin
         errs++;
         $display("FAIL draw_tri_rdy: tri_rdy=%b, required 0", triangle_ready);
      end
      lane_tri_ready = 2'b00;
      finish_frame();
   endtask

   task automatic test_fill_stall();
      int n = 0;
      int stalls = 0;
      begin_frame = 1'b1;
      cyc();
      begin_frame = 1'b0;
      for (int c = 0; c < 40 && n < 8; c++) begin
         out_ready  = !(n == 2 && stalls < 3);
         fill_valid = (n == 1);
         fill_color = 12'h123;
         #1;
         vecs++;
         if (out_valid !== 1'b1 || out_pixel_x !== 16'(n % 4) || out_pixel_y !== 16'(n / 4) ||
             out_color !== 12'hABC) begin
            errs++;
            $display("FAIL stall_px%0d: v=%b (%0d,%0d) c=%h, required 1 (%0d,%0d) abc",
                     n, out_valid, out_pixel_x, out_pixel_y, out_color, n % 4, n / 4);
         end
         if (out_ready) n++;
         else stalls++;
         cyc();
      end
      out_ready  = 1'b1;
      fill_valid = 1'b0;
      #1;
      vecs++;
      if (n != 8 || stalls != 3 || out_valid !== 1'b0 || busy !== 1'b1) begin
         errs++;
         $display("FAIL stall_total: handshakes=%0d stalls=%0d valid=%b busy=%b, required 8/3/0/1",
                  n, stalls, out_valid, busy);
      end
   endtask

   task automatic test_dispatch();
      triangle_t t;
      lane_tri_ready = 2'b11;
      triangle_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         t = '0;
         t.x0 = 16'(i + 5);
         t.color = 12'h700;
         triangle = t;
         #1;
         vecs++;
         if (lane_tri_valid !== ((i % 2 == 0) ? 2'b01 : 2'b10) || triangle_ready !== 1'b1 ||
             lane_triangle !== t) begin
            errs++;
            $display("FAIL dispatch%0d: lane_tri_valid=%b tri_rdy=%b x0=%0d, required %b 1 %0d",
                     i, lane_tri_valid, triangle_ready, lane_triangle.x0,
                     (i % 2 == 0) ? 2'b01 : 2'b10, i + 5);
         end
         cyc();
      end
      lane_tri_ready = 2'b01;
      #1;
      vecs++;
      if (triangle_ready !== 1'b0 || lane_tri_valid !== 2'b10) begin
         errs++;
         $display("FAIL dispatch_block: tri_rdy=%b lane_tri_valid=%b, required 0 10",
                  triangle_ready, lane_tri_valid);
      end
      cyc();
      vecs++;
      if (lane_tri_valid !== 2'b10) begin
         errs++;
         $display("FAIL dispatch_noskip: lane_tri_valid=%b, required 10", lane_tri_valid);
      end
      triangle_valid = 1'b0;
      lane_tri_ready = 2'b00;
   endtask

   task automatic test_merge();
      logic [15:0] ex;
      lane_pixel_x = {16'd30, 16'd10};
      lane_pixel_y = {16'd31, 16'd11};
      lane_depth   = {32'h0000_2222, 32'h0000_1111};
      lane_color   = {12'h222, 12'h111};
      lane_valid   = 2'b11;
      out_ready    = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         ex = (k % 2 == 0) ? 16'd10 : 16'd30;
         vecs++;
         if (out_valid !== 1'b1 || out_pixel_x !== ex || out_compare_depth !== 1'b1 ||
             lane_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10) ||
             out_color !== ((k % 2 == 0) ? 12'h111 : 12'h222)) begin
            errs++;
            $display("FAIL merge%0d: v=%b x=%0d cmp=%b lane_ready=%b c=%h, required x=%0d",
                     k, out_valid, out_pixel_x, out_compare_depth, lane_ready, out_color, ex);
         end
         cyc();
      end
      // prio now points at lane1; only lane0 is valid and is stalled.
      lane_valid = 2'b01;
      out_ready  = 1'b0;
      #1;
      vecs++;
      if (out_valid !== 1'b1 || out_pixel_x !== 16'd10 || lane_ready !== 2'b00) begin
         errs++;
         $display("FAIL stall_grant: v=%b x=%0d lane_ready=%b, required 1 10 00",
                  out_valid, out_pixel_x, lane_ready);
      end
      cyc();
      lane_valid = 2'b11;
      #1;
      vecs++;
      if (out_pixel_x !== 16'd10 || out_depth !== 32'h0000_1111 || lane_ready !== 2'b00) begin
         errs++;
         $display("FAIL stall_lock: x=%0d d=%h lane_ready=%b, required 10 1111 00",
                  out_pixel_x, out_depth, lane_ready);
      end
      cyc();
      out_ready = 1'b1;
      #1;
      vecs++;
      if (out_pixel_x !== 16'd10 || lane_ready !== 2'b01) begin
         errs++;
         $display("FAIL stall_release: x=%0d lane_ready=%b, required 10 01", out_pixel_x, lane_ready);
      end
      cyc();
      vecs++;
      if (out_pixel_x !== 16'd30 || lane_ready !== 2'b10) begin
         errs++;
         $display("FAIL post_stall: x=%0d lane_ready=%b, required 30 10", out_pixel_x, lane_ready);
      end
      lane_valid = 2'b00;
   endtask

   task automatic test_drain();
      int pulses = 0;
      lane_busy   = 2'b10;
      end_frame   = 1'b1;
      cyc();
      end_frame      = 1'b0;
      triangle_valid = 1'b1;
      lane_tri_ready = 2'b11;
      begin_frame    = 1'b1;
      #1;
      vecs++;
      if (triangle_ready !== 1'b0 || lane_tri_valid !== 2'b00 || busy !== 1'b1) begin
         errs++;
         $display("FAIL drain_entry: tri_rdy=%b lane_tri_valid=%b busy=%b, required 0 00 1",
                  triangle_ready, lane_tri_valid, busy);
      end
      for (int k = 0; k < 5; k++) begin
         if (frame_done) pulses++;
         cyc();
         begin_frame = 1'b0;
      end
      triangle_valid = 1'b0;
      lane_tri_ready = 2'b00;
      lane_busy      = 2'b00;
      #1;
      if (frame_done) pulses++;
      cyc();
      vecs++;
      if (frame_done !== 1'b1) begin
         errs++;
         $display("FAIL drain_done: frame_done=%b, required 1", frame_done);
      end
      if (frame_done) pulses++;
      cyc();
      exp_frames++;
      if (frame_done) pulses++;
      vecs++;
      if (pulses != 1 || busy !== 1'b0 || frame_count !== 16'(exp_frames)) begin
         errs++;
         $display("FAIL drain_end: pulses=%0d busy=%b count=%0d, required 1 0 %0d",
                  pulses, busy, frame_count, exp_frames);
      end
      cyc();
      vecs++;
      if (busy !== 1'b0) begin
         errs++;
         $display("FAIL begin_not_queued: busy=%b, required 0", busy);
      end
   endtask

   task automatic test_nofill_and_reset();
      fill_enable = 1'b0;
      begin_frame = 1'b1;
      cyc();
      begin_frame    = 1'b0;
      triangle_valid = 1'b1;
      lane_tri_ready = 2'b10;
      #1;
      vecs++;
      if (busy !== 1'b1 || out_valid !== 1'b0 || lane_tri_valid !== 2'b10 ||
          triangle_ready !== 1'b1) begin
         errs++;
         $display("FAIL nofill_draw: busy=%b v=%b lane_tri_valid=%b tri_rdy=%b, required 1 0 10 1",
                  busy, out_valid, lane_tri_valid, triangle_ready);
      end
      triangle_valid = 1'b0;
      lane_tri_ready = 2'b00;
      finish_frame();
      fill_enable = 1'b1;
      out_ready   = 1'b1;
      begin_frame = 1'b1;
      cyc();
      begin_frame = 1'b0;
      vecs++;
      if (out_valid !== 1'b1 || out_color !== 12'h123 || out_pixel_x !== 16'd0) begin
         errs++;
         $display("FAIL next_fill_color: v=%b c=%h x=%0d, required 1 123 0",
                  out_valid, out_color, out_pixel_x);
      end
      cyc();
      cyc();
      rst = 1'b1;
      cyc();
      vecs++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || frame_count !== 16'd0 || triangle_ready !== 1'b0) begin
         errs++;
         $display("FAIL reset_mid_fill: v=%b busy=%b count=%0d tri_rdy=%b, required 0 0 0 0",
                  out_valid, busy, frame_count, triangle_ready);
      end
      rst = 1'b0;
      cyc();
   endtask

   initial begin
      rst = 1'b1;
      begin_frame = 1'b0;
      end_frame = 1'b0;
      fill_enable = 1'b0;
      fill_color = '0;
      fill_valid = 1'b0;
      triangle = '0;
      triangle_valid = 1'b0;
      lane_tri_ready = '0;
      lane_busy = '0;
      lane_pixel_x = '0;
      lane_pixel_y = '0;
      lane_depth = '0;
      lane_color = '0;
      lane_valid = '0;
      out_ready = 1'b0;
      test_reset();
      test_fill();
      test_fill_stall();
      test_dispatch();
      test_merge();
      test_drain();
      test_nofill_and_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
